// File: rtl/cpu_controller_if.sv
// cpu_controller_if: control bundle between the sequencing FSM and the 16-bit datapath
interface cpu_controller_if #(parameter int SIZE = 16);
    logic            run;
    logic [SIZE-1:0] instr;
    logic [1:0]      flags1out;
    logic [2:0]      flags2out;
    logic            MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL;
    logic [1:0]      PCm, MAm, A2m, RWm;
    logic [3:0]      aluOp, state_dbg;
    modport master (
        input  run, instr, flags1out, flags2out,
        output MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL,
               PCm, MAm, A2m, RWm, aluOp, state_dbg
    );
    modport slave (
        output run, instr, flags1out, flags2out,
        input  MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL,
               PCm, MAm, A2m, RWm, aluOp, state_dbg
    );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle FSM sequencing fetch, decode and execute for the 16-bit datapath
module cpu_controller #(
    parameter int         SIZE   = 16,
    parameter logic [3:0] ADD_OP = 4'b0101
) (
    input logic            clk,
    input logic            reset,
    cpu_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, FWAIT, DECODE, EXEC_R, EXEC_I, LUI, LD_ADDR, LD_WB,
        STORE, JAL, JCOND, BCOND, NOP
    } state_t;
    state_t state, next;
    logic [3:0] op, cond, ext, code;
    logic       taken;
    function automatic logic is_alu(input logic [3:0] c);
        return c inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101};
    endfunction
    assign op   = bus.instr[SIZE-1 -: 4];
    assign cond = bus.instr[SIZE-5 -: 4];
    assign ext  = bus.instr[SIZE-9 -: 4];
    assign code = (state == EXEC_I) ? op : ext;
    // flags: flags1out = {C,F}, flags2out = {Z,N,L}
    assign taken = (cond == 4'b0000) ?  bus.flags2out[2] :
                   (cond == 4'b0001) ? !bus.flags2out[2] :
                   (cond == 4'b0110) ?  bus.flags2out[1] :
                   (cond == 4'b0111) ? !bus.flags2out[1] :
                   (cond == 4'b0010) ?  bus.flags1out[1] :
                   (cond == 4'b0011) ? !bus.flags1out[1] :
                   (cond == 4'b1110);
    assign bus.state_dbg = state;
    assign bus.MemW2en   = 1'b0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= FETCH;
        else        state <= next;
    always_comb begin
        next        = state;
        bus.MemW1en = 1'b0;
        bus.RFen    = 1'b0;
        bus.PSRen   = 1'b0;
        bus.PCen    = 1'b0;
        bus.INSTRen = 1'b0;
        bus.Movm    = 1'b0;
        bus.A1m     = 1'b0;
        bus.setZNL  = 1'b0;
        bus.PCm     = 2'd0;
        bus.MAm     = 2'd0;
        bus.A2m     = 2'd0;
        bus.RWm     = 2'd0;
        bus.aluOp   = 4'd0;
        case (state)
            FETCH: next = bus.run ? FWAIT : FETCH;
            FWAIT: begin
                bus.INSTRen = 1'b1;
                next        = DECODE;
            end
            DECODE: next = (op == 4'b0000) ? (is_alu(ext) ? EXEC_R : NOP) :
                           is_alu(op)      ? EXEC_I :
                           (op == 4'b1111) ? LUI :
                           (op == 4'b1100) ? BCOND :
                           (op != 4'b0100) ? NOP :
                           (ext == 4'b0000) ? LD_ADDR :
                           (ext == 4'b0100) ? STORE :
                           (ext == 4'b1000) ? JAL :
                           (ext == 4'b1100) ? JCOND : NOP;
            EXEC_R, EXEC_I: begin
                bus.A2m   = (state == EXEC_I) ? 2'd2 : 2'd0;
                bus.aluOp = code;
                bus.Movm  = (code != 4'b1101);
                bus.RWm   = 2'd2;
                bus.RFen  = (code != 4'b1011);
                bus.PSRen = code inside {4'b0101, 4'b1001, 4'b1011};
                bus.setZNL = (code == 4'b1011);
                bus.PCen  = 1'b1;
                next      = FETCH;
            end
            LUI: begin
                bus.RWm  = 2'd3;
                bus.RFen = 1'b1;
                bus.PCen = 1'b1;
                next     = FETCH;
            end
            LD_ADDR: begin
                bus.MAm = 2'd1;
                next    = LD_WB;
            end
            LD_WB: begin
                bus.MAm  = 2'd1;
                bus.RFen = 1'b1;
                bus.PCen = 1'b1;
                next     = FETCH;
            end
            STORE: begin
                bus.MAm     = 2'd1;
                bus.MemW1en = 1'b1;
                bus.PCen    = 1'b1;
                next        = FETCH;
            end
            JAL: begin
                bus.RWm  = 2'd1;
                bus.RFen = 1'b1;
                bus.PCen = 1'b1;
                bus.PCm  = 2'd1;
                next     = FETCH;
            end
            JCOND: begin
                bus.PCen = 1'b1;
                bus.PCm  = taken ? 2'd1 : 2'd0;
                next     = FETCH;
            end
            // taken branch: ALU computes PC + sign-extended imm8
            BCOND: begin
                bus.PCen  = 1'b1;
                bus.A1m   = taken;
                bus.A2m   = taken ? 2'd2 : 2'd0;
                bus.aluOp = taken ? ADD_OP : 4'd0;
                bus.PCm   = taken ? 2'd2 : 2'd0;
                next      = FETCH;
            end
            default: begin
                bus.PCen = 1'b1;
                next     = FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven scoreboard bench for the multi-cycle control FSM
module tb_cpu_controller;
    logic clk = 1'b0;
    logic reset;
    cpu_controller_if #(.SIZE(16)) bus();
    cpu_controller #(.SIZE(16), .ADD_OP(4'b0101)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [1:0]  f1;
        logic [2:0]  f2;
        bit          load;
        logic [20:0] exp;
    } vec_t;
    vec_t        vecs[$];
    logic [20:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    localparam logic [20:0] FW = 21'h008000;
    // {MemW1en,MemW2en,RFen,PSRen,PCen,INSTRen,Movm,A1m,setZNL,PCm,MAm,A2m,RWm,aluOp}
    function automatic logic [20:0] mk(input bit mw, rf, psr, pc, movm, a1m, sz,
                                       input logic [1:0] pcm, mam, a2m, rwm, input logic [3:0] alu);
        return {mw, 1'b0, rf, psr, pc, 1'b0, movm, a1m, sz, pcm, mam, a2m, rwm, alu};
    endfunction
    function automatic logic [20:0] outs();
        return {bus.MemW1en, bus.MemW2en, bus.RFen, bus.PSRen, bus.PCen, bus.INSTRen, bus.Movm,
                bus.A1m, bus.setZNL, bus.PCm, bus.MAm, bus.A2m, bus.RWm, bus.aluOp};
    endfunction
    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic run_instr(input vec_t v);
        bus.instr     = v.instr;
        bus.flags1out = v.f1;
        bus.flags2out = v.f2;
        bus.run       = 1'b1;
        sb.push_back(21'h0);
        sb.push_back(FW);
        sb.push_back(21'h0);
        if (v.load) sb.push_back(mk(0,0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd0,4'd0));
        sb.push_back(v.exp);
        while (sb.size() > 0) begin
            @(negedge clk);
            chk(v.name, outs(), sb.pop_front());
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        logic [20:0] pc_only, br_taken;
        pc_only  = mk(0,0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,4'd0);
        br_taken = mk(0,0,0,1,0,1,0, 2'd2,2'd0,2'd2,2'd0,4'd5);
        vecs.push_back('{"add",   16'h0152, 2'b00, 3'b000, 1'b0, mk(0,1,1,1,1,0,0, 2'd0,2'd0,2'd0,2'd2,4'h5)});
        vecs.push_back('{"cmp",   16'h01B2, 2'b00, 3'b000, 1'b0, mk(0,0,1,1,1,0,1, 2'd0,2'd0,2'd0,2'd2,4'hB)});
        vecs.push_back('{"mov",   16'h01D2, 2'b00, 3'b000, 1'b0, mk(0,1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd2,4'hD)});
        vecs.push_back('{"and",   16'h0112, 2'b00, 3'b000, 1'b0, mk(0,1,0,1,1,0,0, 2'd0,2'd0,2'd0,2'd2,4'h1)});
        vecs.push_back('{"subi",  16'h9103, 2'b00, 3'b000, 1'b0, mk(0,1,1,1,1,0,0, 2'd0,2'd0,2'd2,2'd2,4'h9)});
        vecs.push_back('{"ori",   16'h2105, 2'b00, 3'b000, 1'b0, mk(0,1,0,1,1,0,0, 2'd0,2'd0,2'd2,2'd2,4'h2)});
        vecs.push_back('{"cmpi",  16'hB105, 2'b00, 3'b000, 1'b0, mk(0,0,1,1,1,0,1, 2'd0,2'd0,2'd2,2'd2,4'hB)});
        vecs.push_back('{"lui",   16'hF1AB, 2'b00, 3'b000, 1'b0, mk(0,1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd3,4'h0)});
        vecs.push_back('{"load",  16'h4103, 2'b00, 3'b000, 1'b1, mk(0,1,0,1,0,0,0, 2'd0,2'd1,2'd0,2'd0,4'h0)});
        vecs.push_back('{"store", 16'h4143, 2'b00, 3'b000, 1'b0, mk(1,0,0,1,0,0,0, 2'd0,2'd1,2'd0,2'd0,4'h0)});
        vecs.push_back('{"jal",   16'h4E8A, 2'b00, 3'b000, 1'b0, mk(0,1,0,1,0,0,0, 2'd1,2'd0,2'd0,2'd1,4'h0)});
        vecs.push_back('{"beq_t", 16'hC0FE, 2'b00, 3'b100, 1'b0, br_taken});
        vecs.push_back('{"beq_n", 16'hC0FE, 2'b00, 3'b000, 1'b0, pc_only});
        vecs.push_back('{"jne_t", 16'h41C3, 2'b00, 3'b000, 1'b0, mk(0,0,0,1,0,0,0, 2'd1,2'd0,2'd0,2'd0,4'h0)});
        vecs.push_back('{"jcs_n", 16'h42C3, 2'b01, 3'b000, 1'b0, pc_only});
        vecs.push_back('{"bgt_t", 16'hC605, 2'b00, 3'b010, 1'b0, br_taken});
        vecs.push_back('{"ble_n", 16'hC705, 2'b00, 3'b010, 1'b0, pc_only});
        vecs.push_back('{"buc_t", 16'hCE05, 2'b00, 3'b000, 1'b0, br_taken});
        vecs.push_back('{"bnv_n", 16'hC405, 2'b11, 3'b111, 1'b0, pc_only});
        vecs.push_back('{"nop4",  16'h4123, 2'b00, 3'b000, 1'b0, pc_only});
        vecs.push_back('{"nop6",  16'h6000, 2'b00, 3'b000, 1'b0, pc_only});
        vecs.push_back('{"nopr",  16'h0100, 2'b00, 3'b000, 1'b0, pc_only});
        reset = 1'b0;
        bus.run = 1'b0;
        bus.instr = 16'h0;
        bus.flags1out = 2'b00;
        bus.flags2out = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 21'h0);
        chk("reset_state", {17'h0, bus.state_dbg}, 21'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) run_instr(vecs[i]);
        bus.instr = 16'h4103;
        bus.run   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("ld_wb_pre", outs(), mk(0,1,0,1,0,0,0, 2'd0,2'd1,2'd0,2'd0,4'h0));
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", outs(), 21'h0);
        chk("rst_mid_state", {17'h0, bus.state_dbg}, 21'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_fwait", outs(), FW);
        repeat (4) @(posedge clk);
        #1;
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_outs", outs(), 21'h0);
            chk("hold_state", {17'h0, bus.state_dbg}, 21'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
